muldiv_unit: RTL

//   Parametrised iterative multiply/divide unit that owns the architectural HI/LO registers.

---
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that holds the architectural HI/LO registers.
// A mul/div takes WIDTH+1 cycles (WIDTH shift steps plus one sign-fix step); MTHI/MTLO take one.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mf_req,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // state  | meaning
    // S_IDLE | accepts mul/div and MTHI/MTLO
    // S_RUN  | one product/quotient bit per cycle, cnt counts WIDTH..1
    // S_FIX  | apply result signs, write hi/lo, pulse done
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opd;
    logic             op_div, neg_res, neg_rem, div_zero;
    logic             accept, finish;

    logic             is_md, is_mthi, is_mtlo, is_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_md     = op_valid && (op[2] == 1'b0);
    assign is_mthi   = op_valid && (op == 3'b100);
    assign is_mtlo   = op_valid && (op == 3'b101);
    assign is_signed = ~op[0];
    assign a_neg     = is_signed & src_a[WIDTH-1];
    assign b_neg     = is_signed & src_b[WIDTH-1];
    assign a_mag     = a_neg ? (~src_a + WIDTH'(1)) : src_a;
    assign b_mag     = b_neg ? (~src_b + WIDTH'(1)) : src_b;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (is_md) begin
                    state_nxt = S_RUN;
                    accept    = 1'b1;
                end
            end
            S_RUN: begin
                if (cancel)                     state_nxt = S_IDLE;
                else if (cnt == CNT_W'(1))      state_nxt = S_FIX;
            end
            S_FIX: begin
                state_nxt = S_IDLE;
                finish    = ~cancel;
            end
            default: state_nxt = S_IDLE;
        endcase
        stall = busy & (op_valid | mf_req);
    end

    // Multiply keeps the multiplier in acc_lo and shifts the product in from the top;
    // divide shifts the dividend out of acc_lo and the quotient bits in from the bottom.
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opd});
    assign div_sub   = div_shift[WIDTH-1:0] - opd;

    assign prod      = {acc_hi, acc_lo};
    assign prod_fix  = neg_res ? (~prod + (2*WIDTH)'(1)) : prod;
    assign q_fix     = div_zero ? '1 : (neg_res ? (~acc_lo + WIDTH'(1)) : acc_lo);
    assign r_fix     = neg_rem ? (~acc_hi + WIDTH'(1)) : acc_hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opd      <= '0;
            op_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                acc_hi   <= '0;
                acc_lo   <= op[1] ? a_mag : b_mag;
                opd      <= op[1] ? b_mag : a_mag;
                op_div   <= op[1];
                neg_res  <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                div_zero <= (src_b == '0);
                cnt      <= CNT_W'(WIDTH);
            end else if (state == S_RUN) begin
                if (cancel) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                    if (op_div) begin
                        acc_hi <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
            end

            if (finish) begin
                if (op_div) begin
                    hi <= r_fix;
                    lo <= q_fix;
                end else begin
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
                end
            end else if (state == S_IDLE) begin
                if (is_mthi) hi <= src_a;
                if (is_mtlo) lo <= src_a;
            end
        end
    end

endmodule
